// File: rtl/cpu16_param_core.sv
// cpu16_param_core: parameterised multicycle accumulator-style CPU core.
// Four general registers (A..D), external sync-read program/data memories,
// a hardware return-address stack, and valid/ready IN/OUT channels.
module cpu16_param_core #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic              halted,
  output logic              stack_err
);
  localparam int SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_STORE = 6'd1;
  localparam logic [5:0] OP_LOAD  = 6'd2;
  localparam logic [5:0] OP_JUMP  = 6'd3;
  localparam logic [5:0] OP_JNEG  = 6'd4;
  localparam logic [5:0] OP_SUB   = 6'd5;
  localparam logic [5:0] OP_XOR   = 6'd6;
  localparam logic [5:0] OP_OR    = 6'd7;
  localparam logic [5:0] OP_AND   = 6'd8;
  localparam logic [5:0] OP_JPOS  = 6'd9;
  localparam logic [5:0] OP_JZERO = 6'd10;
  localparam logic [5:0] OP_ADDI  = 6'd11;
  localparam logic [5:0] OP_SHL   = 6'd12;
  localparam logic [5:0] OP_SHR   = 6'd13;
  localparam logic [5:0] OP_IN    = 6'd14;
  localparam logic [5:0] OP_OUT   = 6'd15;
  localparam logic [5:0] OP_CALL  = 6'd16;
  localparam logic [5:0] OP_RET   = 6'd17;
  localparam logic [5:0] OP_HALT  = 6'd18;

  typedef enum logic [2:0] {
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_EXEC,
    S_IN_WAIT,
    S_OUT_WAIT,
    S_HALT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [4];
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp;

  logic [5:0]        op;
  logic [1:0]        rsel;
  logic [7:0]        fld;
  logic [ADDR_W-1:0] faddr;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] rval;
  logic [DATA_W-1:0] mem_result;
  logic              stack_full;
  logic              stack_empty;
  logic              push_en;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  // 8-bit immediate widened with its sign bit for ADDI.
  function automatic logic [DATA_W-1:0] sext_imm(input logic [7:0] imm);
    logic signed [7:0]        simm;
    logic signed [DATA_W-1:0] wide;
    simm = imm;
    wide = simm;
    return wide;
  endfunction

  // Opcodes whose result depends on the data memory read launched in DECODE.
  function automatic logic is_mem_op(input logic [5:0] opc);
    return (opc == OP_ADD) || (opc == OP_LOAD) || (opc == OP_SUB) ||
           (opc == OP_XOR) || (opc == OP_OR)   || (opc == OP_AND);
  endfunction

  assign op          = ir[15:10];
  assign rsel        = ir[9:8];
  assign fld         = ir[7:0];
  assign faddr       = ir[ADDR_W-1:0];
  assign rval        = regs[rsel];
  assign pc_next     = pc + ADDR_W'(1);

  assign imem_addr   = pc;
  assign dmem_addr   = faddr;
  assign dmem_wdata  = rval;
  // Store strobe is decoded straight from the state register so that an
  // asynchronous reset removes it in the same instant.
  assign dmem_we     = (state == S_DECODE) && (op == OP_STORE);
  assign in_ready    = (state == S_IN_WAIT);
  assign halted      = (state == S_HALT);

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push_idx    = IDX_W'(sp);
  assign pop_idx     = IDX_W'(sp - SP_W'(1));
  assign push_en     = (state == S_DECODE) && (op == OP_CALL) && !stack_full;

  // Second-operand ALU for memory-sourced instructions, evaluated in EXEC.
  always_comb begin
    mem_result = dmem_rdata;
    case (op)
      OP_ADD:  mem_result = rval + dmem_rdata;
      OP_SUB:  mem_result = rval - dmem_rdata;
      OP_XOR:  mem_result = rval ^ dmem_rdata;
      OP_OR:   mem_result = rval | dmem_rdata;
      OP_AND:  mem_result = rval & dmem_rdata;
      default: mem_result = dmem_rdata;
    endcase
  end

  // Return-address storage; contents are only meaningful below sp, so no reset.
  always_ff @(posedge clock) begin
    if (push_en) stack[push_idx] <= pc;
  end

  // Instruction sequencer: fetch, latch, decode/execute, plus wait/halt states.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      sp        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      stack_err <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          ir    <= imem_rdata;
          pc    <= pc_next;
          state <= S_DECODE;
        end
        S_DECODE: begin
          // pc already points past this instruction here, so it is both the
          // not-taken target and the CALL return address.
          state <= is_mem_op(op) ? S_EXEC : S_FETCH;
          case (op)
            OP_JUMP:  pc <= faddr;
            OP_JNEG:  if (rval[DATA_W-1])  pc <= faddr;
            OP_JPOS:  if (!rval[DATA_W-1]) pc <= faddr;
            OP_JZERO: if (rval == '0)      pc <= faddr;
            OP_ADDI:  regs[rsel] <= rval + sext_imm(fld);
            OP_SHL:   regs[rsel] <= rval << fld[SH_W-1:0];
            OP_SHR:   regs[rsel] <= rval >> fld[SH_W-1:0];
            OP_IN:    state <= S_IN_WAIT;
            OP_OUT: begin
              out_data  <= rval;
              out_valid <= 1'b1;
              state     <= S_OUT_WAIT;
            end
            OP_CALL: begin
              if (stack_full) begin
                stack_err <= 1'b1;
                state     <= S_HALT;
              end else begin
                sp <= sp + SP_W'(1);
                pc <= faddr;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                stack_err <= 1'b1;
                state     <= S_HALT;
              end else begin
                sp <= sp - SP_W'(1);
                pc <= stack[pop_idx];
              end
            end
            OP_HALT: state <= S_HALT;
            default: ;
          endcase
        end
        S_EXEC: begin
          regs[rsel] <= mem_result;
          state      <= S_FETCH;
        end
        S_IN_WAIT: begin
          // in_ready is high throughout this state, so in_valid alone completes it.
          if (in_valid) begin
            regs[rsel] <= in_data;
            state      <= S_FETCH;
          end
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
